// File: rtl/uart_rx_module.sv
// ---------------------------------------------------------------------------
// uart_rx_module
//   8N1 UART receiver. The serial line is synchronized, a falling edge starts
//   a frame, the start bit is re-checked at its middle, eight data bits are
//   sampled LSB first at one-bit spacing, and the stop bit decides between a
//   good byte (Rx_Done_Sig) and a framing error (Frame_Err_Sig).
//
// Parameters
//   CLKS_PER_BIT : CLK cycles per bit period
//   HALF_BIT     : CLK cycles from start-edge detection to the start-bit
//                  mid-sample (2 .. CLKS_PER_BIT-1)
//
// Ports
//   CLK           in   system clock, rising edge
//   RST           in   asynchronous active-high reset
//   RX_Pin_In     in   asynchronous serial line, idle high
//   Rx_En_Sig     in   receive enable, only looked at while idle
//   Rx_Data       out  last correctly framed byte
//   Rx_Done_Sig   out  one-cycle pulse, Rx_Data updated this cycle
//   Frame_Err_Sig out  one-cycle pulse, stop bit was sampled low
//   Rx_Busy       out  high whenever a frame is being received
//   Rx_State_Dbg  out  current FSM state (IDLE=0 START=1 DATA=2 STOP=3)
//
// Handshake: Rx_Done_Sig and Frame_Err_Sig are single-cycle strobes with no
// back-pressure; Rx_Data is stable from the Rx_Done_Sig cycle until the next
// Rx_Done_Sig and is never touched by a framing error.
// ---------------------------------------------------------------------------
module uart_rx_module #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int HALF_BIT     = 5208
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_Pin_In,
  input  logic       Rx_En_Sig,
  output logic [7:0] Rx_Data,
  output logic       Rx_Done_Sig,
  output logic       Frame_Err_Sig,
  output logic       Rx_Busy,
  output logic [1:0] Rx_State_Dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [13:0] BIT_LAST  = 14'(CLKS_PER_BIT - 1);
  localparam logic [13:0] HALF_LAST = 14'(HALF_BIT - 1);

  state_t      state;
  state_t      state_nxt;
  logic        sync1;
  logic        sync2;
  logic        hist;
  logic [13:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;

  logic        start_edge;
  logic        start_go;
  logic        half_tick;
  logic        bit_tick;

  // Two-flop synchronizer plus one history flop; all preset to the idle
  // (high) line level so a reset never looks like a start edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      hist  <= 1'b1;
    end else begin
      sync1 <= RX_Pin_In;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign start_edge = hist & ~sync2;
  assign start_go   = start_edge & Rx_En_Sig;
  assign half_tick  = (cnt == HALF_LAST);
  assign bit_tick   = (cnt == BIT_LAST);

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_go) state_nxt = START;
      end
      START: begin
        // A high line at mid start bit means the edge was only a glitch.
        if (half_tick) state_nxt = sync2 ? IDLE : DATA;
      end
      DATA: begin
        if (bit_tick && (bit_idx == 3'd7)) state_nxt = STOP;
      end
      STOP: begin
        // An edge seen in the very cycle the stop bit is judged is not lost:
        // go straight to START instead of passing through IDLE.
        if (bit_tick) state_nxt = start_go ? START : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: bit timer, bit index, shift register, result and strobes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt           <= 14'd0;
      bit_idx       <= 3'd0;
      shreg         <= 8'h00;
      Rx_Data       <= 8'h00;
      Rx_Done_Sig   <= 1'b0;
      Frame_Err_Sig <= 1'b0;
    end else begin
      Rx_Done_Sig   <= 1'b0;
      Frame_Err_Sig <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= 14'd0;
          bit_idx <= 3'd0;
        end
        START: begin
          if (half_tick) begin
            cnt     <= 14'd0;
            bit_idx <= 3'd0;
          end else begin
            cnt <= cnt + 14'd1;
          end
        end
        DATA: begin
          if (bit_tick) begin
            cnt     <= 14'd0;
            shreg   <= {sync2, shreg[7:1]};
            bit_idx <= 3'(bit_idx + 3'd1);
          end else begin
            cnt <= cnt + 14'd1;
          end
        end
        STOP: begin
          if (bit_tick) begin
            cnt <= 14'd0;
            if (sync2) begin
              Rx_Data     <= shreg;
              Rx_Done_Sig <= 1'b1;
            end else begin
              Frame_Err_Sig <= 1'b1;
            end
          end else begin
            cnt <= cnt + 14'd1;
          end
        end
        default: begin
          cnt     <= 14'd0;
          bit_idx <= 3'd0;
        end
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    Rx_Busy      = (state != IDLE);
    Rx_State_Dbg = state;
  end

endmodule

// File: tb/tb_uart_rx_module.sv
module tb_uart_rx_module;

  localparam int CLKS = 16;
  localparam int HALF = 8;
  localparam int LAT  = 2 + 1 + HALF + 9 * CLKS;

  // ---------------- clock / reset ----------------
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_Pin_In = 1'b1;
  logic       Rx_En_Sig = 1'b1;
  logic [7:0] Rx_Data;
  logic       Rx_Done_Sig;
  logic       Frame_Err_Sig;
  logic       Rx_Busy;
  logic [1:0] Rx_State_Dbg;

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  uart_rx_module #(.CLKS_PER_BIT(CLKS), .HALF_BIT(HALF)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_Pin_In    (RX_Pin_In),
    .Rx_En_Sig    (Rx_En_Sig),
    .Rx_Data      (Rx_Data),
    .Rx_Done_Sig  (Rx_Done_Sig),
    .Frame_Err_Sig(Frame_Err_Sig),
    .Rx_Busy      (Rx_Busy),
    .Rx_State_Dbg (Rx_State_Dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  logic [7:0] last_good = 8'h00;
  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int exp_done = 0;
  int exp_ferr = 0;
  int last_fall_cyc = 0;
  logic prev_done = 1'b0;
  logic prev_ferr = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Sends one 8N1 frame. Reference rule: a frame is accepted when the
  // receiver was enabled at its falling edge; a high stop bit yields the
  // byte, a low stop bit yields a framing error.
  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int drop_en_at);
    logic en_at_start;
    en_at_start = Rx_En_Sig;
    if (en_at_start) begin
      if (stop_val) begin
        exp_q.push_back(b);
        exp_done++;
      end else begin
        exp_ferr++;
      end
    end
    RX_Pin_In = 1'b0;
    last_fall_cyc = cyc;
    for (int i = 0; i < CLKS; i++) begin
      if (i == drop_en_at) Rx_En_Sig = 1'b0;
      tick(1);
    end
    for (int k = 0; k < 8; k++) begin
      RX_Pin_In = b[k];
      tick(CLKS);
    end
    RX_Pin_In = stop_val;
    tick(CLKS);
  endtask

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    if (!RST) begin
      if (Rx_Done_Sig || Frame_Err_Sig)
        check("pulse_exclusive", 32'(Rx_Done_Sig & Frame_Err_Sig), 0);
      if (Rx_Done_Sig) begin
        int lat;
        logic [7:0] e;
        done_cnt++;
        check("done_width", 32'(prev_done), 0);
        check("done_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("rx_data", 32'(Rx_Data), 32'(e));
          last_good = e;
        end
        lat = cyc - last_fall_cyc;
        check("latency", (lat >= LAT - 1 && lat <= LAT + 1) ? LAT : lat, LAT);
      end
      if (Frame_Err_Sig) begin
        ferr_cnt++;
        check("ferr_width", 32'(prev_ferr), 0);
        check("ferr_data_held", 32'(Rx_Data), 32'(last_good));
      end
    end
    prev_done = Rx_Done_Sig;
    prev_ferr = Frame_Err_Sig;
  end

  // ---------------- stimulus ----------------
  initial begin
    int busy_cnt;
    int d0;
    int f0;
    int waited;
    logic [7:0] b;
    logic stop_v;
    int gap;

    // Reset state
    tick(2);
    check("rst_rx_data", 32'(Rx_Data), 0);
    check("rst_done", 32'(Rx_Done_Sig), 0);
    check("rst_ferr", 32'(Frame_Err_Sig), 0);
    check("rst_busy", 32'(Rx_Busy), 0);
    RST = 1'b0;
    tick(5);

    // Single frame 0x55
    send_frame(8'h55, 1'b1, -1);
    tick(CLKS);
    check("frame55_data", 32'(Rx_Data), 32'h55);
    check("frame55_ferr_cnt", ferr_cnt, 0);

    // Back-to-back 0xA3, 0x0F
    send_frame(8'hA3, 1'b1, -1);
    send_frame(8'h0F, 1'b1, -1);
    tick(CLKS);
    check("b2b_done_cnt", done_cnt, 3);
    check("b2b_last", 32'(Rx_Data), 32'h0F);

    // 4-cycle low glitch
    d0 = done_cnt;
    f0 = ferr_cnt;
    busy_cnt = 0;
    RX_Pin_In = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 4) RX_Pin_In = 1'b1;
      tick(1);
      if (Rx_Busy) busy_cnt++;
    end
    check("glitch_busy_seen", 32'(busy_cnt > 0), 1);
    check("glitch_busy_max", (busy_cnt <= HALF + 3) ? 0 : busy_cnt, 0);
    check("glitch_idle", 32'(Rx_Busy), 0);
    check("glitch_no_done", done_cnt, d0);
    check("glitch_no_ferr", ferr_cnt, f0);

    // Framing error then break
    send_frame(8'hFF, 1'b0, -1);
    busy_cnt = 0;
    for (int i = 0; i < 3 * CLKS; i++) begin
      tick(1);
      if (Rx_Busy) busy_cnt++;
    end
    check("break_ferr_cnt", ferr_cnt, exp_ferr);
    check("break_no_restart", busy_cnt, 0);
    check("break_data_held", 32'(Rx_Data), 32'h0F);
    RX_Pin_In = 1'b1;
    tick(2 * CLKS);
    send_frame(8'h5A, 1'b1, -1);
    tick(CLKS);
    check("after_break_data", 32'(Rx_Data), 32'h5A);

    // Reset during data bit 4 of 0x3C
    d0 = done_cnt;
    b = 8'h3C;
    RX_Pin_In = 1'b0;
    tick(CLKS);
    for (int k = 0; k < 4; k++) begin
      RX_Pin_In = b[k];
      tick(CLKS);
    end
    RX_Pin_In = b[4];
    tick(5);
    RST = 1'b1;
    last_good = 8'h00;
    tick(2);
    check("midrst_data", 32'(Rx_Data), 0);
    check("midrst_busy", 32'(Rx_Busy), 0);
    RST = 1'b0;
    RX_Pin_In = 1'b1;
    tick(2 * CLKS);
    check("midrst_no_done", done_cnt, d0);
    send_frame(8'h81, 1'b1, -1);
    tick(CLKS);
    check("midrst_then_81", 32'(Rx_Data), 32'h81);

    // Enable behaviour
    d0 = done_cnt;
    Rx_En_Sig = 1'b0;
    send_frame(8'h12, 1'b1, -1);
    tick(CLKS);
    check("en_off_no_rx", done_cnt, d0);
    check("en_off_busy", 32'(Rx_Busy), 0);
    Rx_En_Sig = 1'b1;
    send_frame(8'h34, 1'b1, 6);
    tick(CLKS);
    check("en_drop_rx", 32'(Rx_Data), 32'h34);
    Rx_En_Sig = 1'b1;

    // Randomized frames with random gaps and occasional bad stop bits
    for (int n = 0; n < 24; n++) begin
      b = 8'($urandom_range(0, 255));
      stop_v = ($urandom_range(0, 5) != 0);
      gap = $urandom_range(0, 40);
      send_frame(b, stop_v, -1);
      if (!stop_v) gap = gap + 4;
      RX_Pin_In = 1'b1;
      tick(gap);
    end

    // Drain
    waited = 0;
    while (exp_q.size() != 0 && waited < 20 * CLKS) begin
      tick(1);
      waited++;
    end
    tick(2 * CLKS);
    check("queue_drained", exp_q.size(), 0);
    check("done_count", done_cnt, exp_done);
    check("ferr_count", ferr_cnt, exp_ferr);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_module.md
UART_RX_MODULE -- requirements
Module: uart_rx_module

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10417, means CLK cycles per bit period (9600 baud at 100 MHz).
REQ-002 Parameter HALF_BIT, default 5208, means CLK cycles from start-edge detection to the start-bit mid-sample; legal range 2..CLKS_PER_BIT-1.
REQ-003 Port CLK, input, 1 bit: system clock; all logic on the rising edge.
REQ-004 Port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port RX_Pin_In, input, 1 bit: asynchronous serial line, idle high.
REQ-006 Port Rx_En_Sig, input, 1 bit: receive enable; sampled in IDLE only.
REQ-007 Port Rx_Data, output, 8 bits: last correctly framed byte.
REQ-008 Port Rx_Done_Sig, output, 1 bit: one-cycle pulse; Rx_Data was updated this cycle.
REQ-009 Port Frame_Err_Sig, output, 1 bit: one-cycle pulse; stop bit sampled low.
REQ-010 Port Rx_Busy, output, 1 bit: high in every state except IDLE.

Function
REQ-011 RX_Pin_In SHALL pass through a 2-flop synchronizer, then one further history flop; start edge = history 1 and synchronized value 0.
REQ-012 FSM states SHALL be: IDLE, START, DATA, STOP.
REQ-013 IDLE -> START on a start edge with Rx_En_Sig=1; bit counter cleared; otherwise stay in IDLE.
REQ-014 START: counter increments each cycle; at count HALF_BIT-1 sample the line: 0 -> DATA with counter cleared, bit index 0; 1 -> IDLE (glitch rejected, no output pulse).
REQ-015 DATA: counter runs 0..CLKS_PER_BIT-1 and wraps to 0; at CLKS_PER_BIT-1 the sampled bit SHALL shift in LSB first; after bit index 7 -> STOP.
REQ-016 STOP: at count CLKS_PER_BIT-1 sample the line: 1 -> Rx_Data <= shift register, Rx_Done_Sig=1 next cycle; 0 -> Frame_Err_Sig=1 next cycle, Rx_Data unchanged; both cases -> IDLE.
REQ-017 Rx_Done_Sig and Frame_Err_Sig SHALL each be high for exactly one CLK and never high together.
REQ-018 Latency: Rx_Done_Sig SHALL rise 2+1+HALF_BIT+9*CLKS_PER_BIT cycles (+/-1) after the line's falling edge.
REQ-019 Rx_En_Sig deasserted mid-frame SHALL NOT abort the frame in progress.
REQ-020 After a framing error with the line held low (break), no new frame SHALL start until the line returns high and falls again.
REQ-021 Counter width SHALL be 14 bits; counter held at 0 in IDLE.
REQ-022 A start edge arriving in the cycle of the STOP->IDLE transition SHALL be accepted if the history flop shows 1 in that cycle.

Reset
REQ-023 RST=1 SHALL force IDLE, counter=0, bit index=0, shift register=0x00, Rx_Data=0x00, Rx_Done_Sig=0, Frame_Err_Sig=0, Rx_Busy=0, synchronizer and history flops=1, within the same cycle, independent of CLK.
REQ-024 RST asserted mid-frame SHALL discard the partial byte and emit no pulse; the first frame after release SHALL be received normally.

Verification (CLKS_PER_BIT=16, HALF_BIT=8)
REQ-025 Frame 0x55, 8N1, at exact bit timing -> one Rx_Done_Sig pulse, Rx_Data=0x55, Frame_Err_Sig stays 0.
REQ-026 Back-to-back frames 0xA3 then 0x0F with zero idle between -> two Rx_Done_Sig pulses; Rx_Data 0xA3 then 0x0F.
REQ-027 Low glitch of 4 cycles on the idle line -> return to IDLE after START, no pulses, Rx_Busy high for at most HALF_BIT+3 cycles.
REQ-028 Frame 0xFF with stop bit driven low -> Frame_Err_Sig pulse; Rx_Data holds the previous value; line held low afterwards -> no new frame until a high-then-low transition.
REQ-029 RST pulsed during data bit 4 of 0x3C, then a clean frame 0x81 -> no pulse for 0x3C; Rx_Data=0x81 with one Rx_Done_Sig.
REQ-030 Rx_En_Sig=0 while a frame 0x12 is sent -> no reception; Rx_En_Sig dropped after START entry of frame 0x34 -> Rx_Data=0x34 received.
